// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, imem read handshake and fetch buffer feeding the decode ROM.
//   clk, rst                 clock, async active-high reset
//   imem_address/imem_read   outgoing read request (held until imem_resp)
//   imem_resp/imem_rdata     1-cycle response pulse with instruction word
//   redirect/redirect_pc     branch/jump target, squashes in-flight fetch
//   stall                    decode not ready, head entry held
//   valid_o/pc_o/instr_o     head entry; instr_o is nop when empty
//   opcode/funct3/funct7     decode ROM slices of instr_o
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000060,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;
  typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;
  state_t state;
  logic [31:0] fetch_pc, req_addr;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [31:0] pc_mem [FIFO_DEPTH];
  logic [31:0] ins_mem [FIFO_DEPTH];
  logic push, pop, issue;
  // a redirect cycle suppresses push/pop; a new request is issued only when the
  // post-push/pop occupancy leaves room for its data
  always_comb begin
    push = state == REQ && imem_resp && !redirect;
    pop = valid_o && !stall && !redirect;
    count_next = count + CW'(push) - CW'(pop);
    issue = !redirect && ((state == IDLE && count < FULL) || (state == REQ && imem_resp && count_next < FULL));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      state <= (state == IDLE || imem_resp) ? IDLE : SQUASH;
    end else begin
      count <= count_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (issue) begin
        req_addr <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
        state <= REQ;
      end else if (imem_resp && state != IDLE) begin
        state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr] <= req_addr;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end
  assign imem_read = state == REQ || state == SQUASH;
  assign imem_address = req_addr;
  assign valid_o = count != '0;
  assign pc_o = valid_o ? pc_mem[rd_ptr] : 32'h0;
  assign instr_o = valid_o ? ins_mem[rd_ptr] : NOP;
  assign opcode = instr_o[6:0];
  assign funct3 = instr_o[14:12];
  assign funct7 = instr_o[31:25];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, buffering, redirect and reset behaviour.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] imem_address;
  logic imem_read;
  logic imem_resp = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic stall = 1'b0;
  logic valid_o;
  logic [31:0] pc_o, instr_o;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  int checks = 0;
  int errors = 0;
  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_address(imem_address), .imem_read(imem_read),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .stall(stall), .valid_o(valid_o), .pc_o(pc_o),
    .instr_o(instr_o), .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // memory returns ~address; answers only while a read is pending
  task automatic mem_cyc(input bit r);
    imem_resp = r && imem_read;
    imem_rdata = ~imem_address;
    step();
    imem_resp = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    imem_resp = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask
  initial begin
    // reset state
    step();
    chk("rst_read", 32'(imem_read), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instr", instr_o, 32'h00000013);
    chk("rst_addr", imem_address, 32'h60);
    // 1: basic fetch, response one cycle after request
    do_reset();
    chk("t1_read", 32'(imem_read), 32'd1);
    chk("t1_addr0", imem_address, 32'h60);
    mem_cyc(0);
    chk("t1_valid_pre", 32'(valid_o), 32'd0);
    mem_cyc(1);
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_pc", pc_o, 32'h60);
    chk("t1_instr", instr_o, 32'hFFFFFF9F);
    chk("t1_opcode", 32'(opcode), 32'h1F);
    chk("t1_funct3", 32'(funct3), 32'h7);
    chk("t1_funct7", 32'(funct7), 32'h7F);
    chk("t1_addr1", imem_address, 32'h64);
    mem_cyc(0);
    chk("t1_popped", 32'(valid_o), 32'd0);
    mem_cyc(1);
    chk("t1_pc1", pc_o, 32'h64);
    chk("t1_addr2", imem_address, 32'h68);
    // 2: stall fills the buffer, then drains in order
    do_reset();
    stall = 1'b1;
    mem_cyc(1);
    chk("t2_addr", imem_address, 32'h64);
    mem_cyc(1);
    chk("t2_full_read", 32'(imem_read), 32'd0);
    chk("t2_head", pc_o, 32'h60);
    mem_cyc(1);
    chk("t2_hold_read", 32'(imem_read), 32'd0);
    chk("t2_hold_pc", pc_o, 32'h60);
    stall = 1'b0;
    mem_cyc(1);
    chk("t2_pc2", pc_o, 32'h64);
    chk("t2_instr2", instr_o, 32'hFFFFFF9B);
    chk("t2_read_still", 32'(imem_read), 32'd0);
    mem_cyc(1);
    chk("t2_resume_read", 32'(imem_read), 32'd1);
    chk("t2_resume_addr", imem_address, 32'h68);
    chk("t2_empty", 32'(valid_o), 32'd0);
    // 3: redirect while a read is pending
    do_reset();
    mem_cyc(1);
    chk("t3_valid", 32'(valid_o), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("t3_sq_read", 32'(imem_read), 32'd1);
    chk("t3_sq_addr", imem_address, 32'h64);
    chk("t3_flushed", 32'(valid_o), 32'd0);
    mem_cyc(0);
    chk("t3_sq_addr2", imem_address, 32'h64);
    mem_cyc(1);
    chk("t3_dropped", 32'(valid_o), 32'd0);
    chk("t3_idle", 32'(imem_read), 32'd0);
    mem_cyc(0);
    chk("t3_new_addr", imem_address, 32'h200);
    chk("t3_new_read", 32'(imem_read), 32'd1);
    chk("t3_still_empty", 32'(valid_o), 32'd0);
    mem_cyc(1);
    chk("t3_new_pc", pc_o, 32'h200);
    chk("t3_new_instr", instr_o, 32'hFFFFFDFF);
    // 4: redirect coinciding with the response
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'h103;
    imem_resp = 1'b1;
    imem_rdata = 32'hFFFFFF9F;
    step();
    redirect = 1'b0;
    imem_resp = 1'b0;
    chk("t4_valid", 32'(valid_o), 32'd0);
    chk("t4_read", 32'(imem_read), 32'd0);
    mem_cyc(0);
    chk("t4_addr", imem_address, 32'h100);
    // 5: wrap of the fetch PC
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    imem_resp = 1'b1;
    step();
    redirect = 1'b0;
    imem_resp = 1'b0;
    mem_cyc(0);
    chk("t5_addr_top", imem_address, 32'hFFFFFFFC);
    mem_cyc(1);
    chk("t5_addr_wrap", imem_address, 32'h0);
    chk("t5_pc", pc_o, 32'hFFFFFFFC);
    chk("t5_instr", instr_o, 32'h00000003);
    // 6: reset mid-request
    do_reset();
    mem_cyc(1);
    chk("t6_pre_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_read", 32'(imem_read), 32'd0);
    chk("t6_valid", 32'(valid_o), 32'd0);
    chk("t6_pc", pc_o, 32'h0);
    step();
    rst = 1'b0;
    imem_resp = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    step();
    imem_resp = 1'b0;
    chk("t6_stray_valid", 32'(valid_o), 32'd0);
    chk("t6_refetch", imem_address, 32'h60);
    chk("t6_refetch_read", 32'(imem_read), 32'd1);
    mem_cyc(1);
    chk("t6_pc_after", pc_o, 32'h60);
    chk("t6_instr_after", instr_o, 32'hFFFFFF9F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
